// File: rtl/bus_halt_watchdog_pkg.sv
// Shared types and default channel map for the bus halt watchdog.
// The default map gives four 256-byte windows starting at address 0.
package bus_halt_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  localparam logic [127:0] DEF_CH_BASE = {
    32'h0000_0300, 32'h0000_0200,
    32'h0000_0100, 32'h0000_0000
  };

  localparam logic [127:0] DEF_CH_LAST = {
    32'h0000_03FF, 32'h0000_02FF,
    32'h0000_01FF, 32'h0000_00FF
  };

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational range decoder; the lowest matching channel wins.
// Produces a hit flag and a one-hot channel select.
module bus_addr_decode
  import bus_halt_watchdog_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = DEF_CH_BASE,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_LAST = DEF_CH_LAST
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [NUM_CH-1:0] sel
);

  // Scan high to low so the lowest index overwrites last.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (addr >= CH_BASE[i*ADDR_W +: ADDR_W] &&
          addr <= CH_LAST[i*ADDR_W +: ADDR_W]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_halt_watchdog.sv
// Stalls the CPU while a downstream channel completes a request,
// returning error data and flagging a sticky error on miss/timeout.
module bus_halt_watchdog
  import bus_halt_watchdog_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = DEF_CH_BASE,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_LAST = DEF_CH_LAST,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  output logic                     cpu_halt_o,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     cpu_rvalid_o,
  output logic [NUM_CH-1:0]        ch_req_o,
  output logic                     ch_we_o,
  output logic [ADDR_W-1:0]        ch_addr_o,
  output logic [DATA_W-1:0]        ch_wdata_o,
  input  logic [NUM_CH-1:0]        ch_ack_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  input  logic                     err_clr_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [NUM_CH-1:0]   sel_q;
  logic [NUM_CH-1:0]   dec_sel;
  logic [NUM_CH-1:0]   ch_req_q;
  logic                dec_hit;
  logic                take;
  logic                ack_hit;
  logic                err_set;
  logic                rd_ld;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [ADDR_W-1:0]   err_src;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   ack_data;
  logic [DATA_W-1:0]   rd_val;

  bus_addr_decode #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .CH_BASE (CH_BASE),
    .CH_LAST (CH_LAST)
  ) u_dec (
    .addr (cpu_addr_i),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign take    = (state_q == IDLE) && cpu_req_i;
  assign ack_hit = |(ch_ack_i & sel_q);
  assign err_src = (state_q == IDLE) ? cpu_addr_i : addr_q;

  always_comb begin
    ack_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q[i]) begin
        ack_data = ack_data | ch_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // An ack on the expiry cycle is checked first so it beats the timeout.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    rd_ld   = 1'b0;
    rd_val  = ERR_DATA;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (dec_hit) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            err_set = 1'b1;
            rd_ld   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (ack_hit) begin
          state_d = DONE;
          rd_ld   = 1'b1;
          rd_val  = ack_data;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          err_set = 1'b1;
          rd_ld   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      ch_req_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      ch_req_q <= (take && dec_hit) ? dec_sel : '0;
      if (take) begin
        we_q <= cpu_we_i;
      end
      if (take && dec_hit) begin
        sel_q   <= dec_sel;
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
      end
      if (rd_ld) begin
        rdata_q <= rd_val;
      end
      // A new error beats a same-cycle clear and captures its address.
      if (err_set) begin
        err_q <= 1'b1;
        if (!err_q || err_clr_i) begin
          err_addr_q <= err_src;
        end
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign cpu_halt_o   = !reset_i &&
                        ((state_q == WAIT) || (take && dec_hit));
  assign cpu_rvalid_o = !reset_i && (state_q == DONE) && !we_q;
  assign cpu_rdata_o  = rdata_q;
  assign ch_req_o     = ch_req_q;
  assign ch_we_o      = we_q;
  assign ch_addr_o    = addr_q;
  assign ch_wdata_o   = wdata_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_bus_halt_watchdog.sv
// Bench for bus_halt_watchdog: directed table, random transactions
// against a transaction-level model, and a reset-in-WAIT sequence.
module tb_bus_halt_watchdog;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam logic [127:0] BASE = {
    32'h300, 32'h200, 32'h100, 32'h000};
  localparam logic [127:0] LAST = {
    32'h3FF, 32'h2FF, 32'h1FF, 32'h0FF};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic         cpu_halt_o;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_rvalid_o;
  logic [3:0]   ch_req_o;
  logic         ch_we_o;
  logic [31:0]  ch_addr_o;
  logic [31:0]  ch_wdata_o;
  logic [3:0]   ch_ack_i;
  logic [127:0] ch_rdata_i;
  logic         err_o;
  logic [31:0]  err_addr_o;
  logic         err_clr_i;

  always #5 clk = ~clk;

  bus_halt_watchdog #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CH_BASE (BASE),
    .CH_LAST (LAST),
    .ERR_DATA(ERRD)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_halt_o  (cpu_halt_o),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_rvalid_o(cpu_rvalid_o),
    .ch_req_o    (ch_req_o),
    .ch_we_o     (ch_we_o),
    .ch_addr_o   (ch_addr_o),
    .ch_wdata_o  (ch_wdata_o),
    .ch_ack_i    (ch_ack_i),
    .ch_rdata_i  (ch_rdata_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_clr_i   (err_clr_i)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model of the sticky error flag and its captured address.
  logic        m_err;
  logic [31:0] m_eaddr;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;
    logic [31:0] adata;
    int          spur;
    int          clr;
    int          e_halt;
    logic [3:0]  e_req;
    int          e_rv;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_eaddr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic idle_in();
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    ch_ack_i    = '0;
    ch_rdata_i  = '0;
    err_clr_i   = 1'b0;
  endtask

  // One transaction, cycle 0 = request cycle. Expected behaviour is
  // derived from the address map and the ack cycle alone.
  task automatic run_txn(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          ack_cyc,
    input  logic [31:0] adata,
    input  int          spur,
    input  int          clr,
    input  bit          noise,
    output int          o_halt,
    output logic [3:0]  o_req,
    output int          o_rv,
    output logic [31:0] o_rd);
    bit          mapped;
    bit          acked;
    int          k;
    int          e;
    logic [31:0] got;
    logic [3:0]  emsk;
    logic [3:0]  oth;
    logic [3:0]  ack;
    logic [127:0] rd;
    logic        clr_now;
    mapped = addr < 32'h400;
    k      = int'(addr[9:8]);
    acked  = mapped && ack_cyc >= 1 && ack_cyc <= TIMEOUT;
    e      = !mapped ? 1 : (acked ? ack_cyc + 1 : TIMEOUT + 1);
    got    = acked ? adata : ERRD;
    emsk   = mapped ? 4'(1 << k) : 4'b0;
    o_halt = 0;
    o_req  = '0;
    o_rv   = -1;
    o_rd   = '0;
    for (int c = 0; c <= e; c++) begin
      rd  = {$urandom, $urandom, $urandom, $urandom};
      oth = noise ? 4'($urandom) : 4'b0;
      if (c == 0 || c == e) begin
        ack = oth;
      end else if (c == ack_cyc) begin
        ack = oth | emsk;
        rd[k*32 +: 32] = adata;
      end else begin
        ack = oth & ~emsk;
        if (spur >= 0) ack[spur] = 1'b1;
      end
      clr_now = (c == clr) ||
                (noise && $urandom_range(7) == 0);
      cpu_req_i   = (c == 0) ||
                    (noise && $urandom_range(1) == 1);
      cpu_we_i    = (c == 0) ? we : 1'($urandom);
      cpu_addr_i  = (c == 0) ? addr : $urandom;
      cpu_wdata_i = (c == 0) ? wdata : $urandom;
      ch_ack_i    = ack;
      ch_rdata_i  = rd;
      err_clr_i   = clr_now;
      #3;
      chk($sformatf("halt c%0d a%0h", c, addr),
          cpu_halt_o, mapped && c < e);
      chk($sformatf("ch_req c%0d a%0h", c, addr),
          ch_req_o, (c == 1) ? emsk : 4'b0);
      chk($sformatf("rvalid c%0d a%0h", c, addr),
          cpu_rvalid_o, c == e && !we);
      chk($sformatf("err c%0d a%0h", c, addr), err_o, m_err);
      chk($sformatf("err_addr c%0d a%0h", c, addr),
          err_addr_o, m_eaddr);
      if (c == e && !we)
        chk($sformatf("rdata a%0h", addr), cpu_rdata_o, got);
      if (mapped && c == 1)
        chk($sformatf("ch_bus a%0h", addr),
            {ch_we_o, ch_addr_o, ch_wdata_o}, {we, addr, wdata});
      if (cpu_halt_o) o_halt++;
      if (c == 1) o_req = ch_req_o;
      if (cpu_rvalid_o && o_rv < 0) o_rv = c;
      if (c == e) o_rd = cpu_rdata_o;
      if (!acked && c == e - 1) begin
        if (!m_err || clr_now) m_eaddr = addr;
        m_err = 1'b1;
      end else if (clr_now) begin
        m_err = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    idle_in();
  endtask

  initial begin
    int          oh;
    int          orv;
    logic [3:0]  oreq;
    logic [31:0] ord;
    logic [31:0] ra;

    tbl[0] = '{1'b0, 32'h104, 32'h0, 1, 32'h1234_5678, -1, -1,
               2, 4'b0010, 2, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h010, 32'hCAFE_0010, 4, 32'h0, 3, -1,
               5, 4'b0001, -1, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h400, 32'h0, 1, 32'h0, -1, -1,
               0, 4'b0000, 1, ERRD, 1'b1, 32'h400};
    tbl[3] = '{1'b0, 32'h500, 32'h0, 1, 32'h0, -1, -1,
               0, 4'b0000, 1, ERRD, 1'b1, 32'h400};
    tbl[4] = '{1'b0, 32'h208, 32'h0, 0, 32'h0, -1, 16,
               17, 4'b0100, 17, ERRD, 1'b1, 32'h208};
    tbl[5] = '{1'b0, 32'h3F0, 32'h0, 16, 32'hA5A5_0F0F, -1, 0,
               17, 4'b1000, 17, 32'hA5A5_0F0F, 1'b0, 32'h208};
    tbl[6] = '{1'b1, 32'h2FF, 32'h7777_0001, 3, 32'h0, -1, -1,
               4, 4'b0100, -1, 32'h0, 1'b0, 32'h208};

    idle_in();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    #3;
    chk("rst halt", cpu_halt_o, 1'b0);
    chk("rst ch_req", ch_req_o, 4'b0);
    chk("rst rvalid", cpu_rvalid_o, 1'b0);
    chk("rst rdata", cpu_rdata_o, 32'h0);
    chk("rst err", err_o, 1'b0);
    chk("rst err_addr", err_addr_o, 32'h0);
    chk("rst ch_bus", {ch_we_o, ch_addr_o, ch_wdata_o}, 65'h0);
    m_err   = 1'b0;
    m_eaddr = '0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].ack_cyc, tbl[i].adata, tbl[i].spur,
              tbl[i].clr, 1'b0, oh, oreq, orv, ord);
      chk($sformatf("v%0d halt cycles", i), oh, tbl[i].e_halt);
      chk($sformatf("v%0d ch_req", i), oreq, tbl[i].e_req);
      chk($sformatf("v%0d rvalid cycle", i), orv, tbl[i].e_rv);
      if (!tbl[i].we)
        chk($sformatf("v%0d rdata", i), ord, tbl[i].e_rdata);
      #3;
      chk($sformatf("v%0d err", i), err_o, tbl[i].e_err);
      chk($sformatf("v%0d err_addr", i),
          err_addr_o, tbl[i].e_eaddr);
      @(posedge clk);
      #1;
    end

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) != 0) ra = $urandom_range(32'h3FF);
      else ra = 32'h400 + $urandom_range(32'hFFFF);
      run_txn(1'($urandom), ra, $urandom,
              int'($urandom_range(1, 20)), $urandom, -1, -1,
              1'b1, oh, oreq, orv, ord);
    end

    // Reset in the third WAIT cycle abandons the read silently.
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h120;
    #3;
    chk("rstwait halt c0", cpu_halt_o, 1'b1);
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    for (int c = 1; c < 3; c++) begin
      #3;
      chk($sformatf("rstwait halt c%0d", c), cpu_halt_o, 1'b1);
      if (c == 1) chk("rstwait ch_req", ch_req_o, 4'b0010);
      @(posedge clk);
      #1;
    end
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    m_err   = 1'b0;
    m_eaddr = '0;
    for (int c = 4; c < 10; c++) begin
      ch_ack_i = (c == 5) ? 4'b0010 : 4'b0;
      #3;
      chk($sformatf("rstwait halt c%0d", c), cpu_halt_o, 1'b0);
      chk($sformatf("rstwait rvalid c%0d", c), cpu_rvalid_o, 1'b0);
      chk($sformatf("rstwait err c%0d", c), err_o, m_err);
      chk($sformatf("rstwait eaddr c%0d", c), err_addr_o, m_eaddr);
      chk($sformatf("rstwait req c%0d", c), ch_req_o, 4'b0);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
